// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: port 1 is a TX FIFO / RX holding register, port 2 is status/control.
// Optional interrupt output and enables are built when IO_IRQ_EN is defined.
module io_port_responder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io1_write,
  input  logic              io1_read,
  input  logic              io2_write,
  input  logic              io2_read,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
`ifdef IO_IRQ_EN
  ,output logic             irq
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rx_word_q, rx_word_d;
  logic              rx_full_q, rx_full_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic [1:0]        ien_q, ien_d;
  logic              irq_q, irq_d;

  logic        full, empty, flush, pop, push, capture, ovf_set, unf_set;
  logic [31:0] status;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = ~empty;
  assign tx_data  = mem_q[rd_ptr_q];
  assign rx_ready = ~rx_full_q;

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
`ifdef IO_IRQ_EN
  assign irq = irq_q;
`endif

  // Strobe decode; flush overrides both push and pop in the same cycle.
  always_comb begin
    flush   = io2_write & write_data[2];
    pop     = tx_valid & tx_ready & ~flush;
    push    = io1_write & ~flush & (~full | (tx_valid & tx_ready));
    ovf_set = io1_write & ~flush & full & ~(tx_valid & tx_ready);
    capture = rx_valid & ~rx_full_q;
    unf_set = io1_read & ~rx_full_q;
  end

  // Status word samples pre-edge state.
  always_comb begin
    status = '0;
    status[0] = full;
    status[1] = empty;
    status[2] = rx_full_q;
    status[3] = overflow_q;
    status[4] = underflow_q;
`ifdef IO_IRQ_EN
    status[6:5] = ien_q;
`endif
    status[8 +: CNT_W] = count_q;
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rx_word_d    = rx_word_q;
    rx_full_d    = rx_full_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    ien_d        = ien_q;
    irq_d        = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = write_data[DATA_W-1:0];
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // io1_read takes priority over io2_read on the load bus.
    if (io1_read) begin
      read_valid_d = 1'b1;
      read_data_d  = rx_full_q ? 32'(rx_word_q) : 32'd0;
    end else if (io2_read) begin
      read_valid_d = 1'b1;
      read_data_d  = status;
    end

    if (capture) begin
      rx_word_d = rx_data;
    end
    rx_full_d = capture | (rx_full_q & ~io1_read);

    // Sticky bits: a set in the same cycle as a clear wins.
    overflow_d  = (overflow_q  & ~(io2_write & write_data[0])) | ovf_set;
    underflow_d = (underflow_q & ~(io2_write & write_data[1])) | unf_set;

`ifdef IO_IRQ_EN
    if (io2_write) begin
      ien_d = write_data[4:3];
    end
    irq_d = (rx_full_q & ien_q[0]) | (empty & ien_q[1]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rx_word_q    <= '0;
      rx_full_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      ien_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rx_word_q    <= rx_word_d;
      rx_full_q    <= rx_full_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      ien_q        <= ien_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder (DEPTH=4, DATA_W=32); irq checks built with IO_IRQ_EN.
module tb_io_port_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        io1_write, io1_read, io2_write, io2_read;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready;
`ifdef IO_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_port_responder #(.DEPTH(4), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .io1_write  (io1_write),
    .io1_read   (io1_read),
    .io2_write  (io2_write),
    .io2_read   (io2_read),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready)
`ifdef IO_IRQ_EN
    ,.irq       (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs settle 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    io2_read = 1'b1;
    step();
    io2_read = 1'b0;
    check(tag, read_data, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    io1_write  = 1'b1;
    write_data = w;
    step();
    io1_write  = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] w);
    io2_write  = 1'b1;
    write_data = w;
    step();
    io2_write  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    io1_write = 0; io1_read = 0; io2_write = 0; io2_read = 0;
    write_data = '0; tx_ready = 0; rx_data = '0; rx_valid = 0;
    step();
    step();
    rst = 1'b0;

    check("rst_read_data", read_data, 32'h0);
    check("rst_read_valid", {31'b0, read_valid}, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    read_status("rst_status", 32'h0000_0002);
    check("status_valid_pulse", {31'b0, read_valid}, 32'h1);
    step();
    check("valid_drops", {31'b0, read_valid}, 32'h0);
    check("read_data_holds", read_data, 32'h0000_0002);

    // Fill past capacity with the sink stalled.
    for (int i = 0; i < 5; i++) push_word(32'h11 + 32'(i));
    read_status("ovf_status", 32'h0000_0409);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'b0, tx_valid}, 32'h1);
      check("drain_data", tx_data, 32'h11 + 32'(i));
      step();
    end
    tx_ready = 1'b0;
    check("drain_empty", {31'b0, tx_valid}, 32'h0);
    ctrl_write(32'h1);
    read_status("ovf_cleared", 32'h0000_0002);

    // Push into a full FIFO while the head is popped.
    for (int i = 0; i < 4; i++) push_word(32'h21 + 32'(i));
    tx_ready = 1'b1;
    push_word(32'hAA);
    tx_ready = 1'b0;
    read_status("full_pop_status", 32'h0000_0401);
    tx_ready = 1'b1;
    check("fp_d0", tx_data, 32'h22); step();
    check("fp_d1", tx_data, 32'h23); step();
    check("fp_d2", tx_data, 32'h24); step();
    check("fp_d3", tx_data, 32'hAA); step();
    tx_ready = 1'b0;
    check("fp_empty", {31'b0, tx_valid}, 32'h0);

    // RX capture, read, then read while empty.
    rx_valid = 1'b1; rx_data = 32'hCAFE;
    step();
    rx_valid = 1'b0;
    check("rx_ready_low", {31'b0, rx_ready}, 32'h0);
    io1_read = 1'b1;
    step();
    check("rx_read_data", read_data, 32'h0000_CAFE);
    check("rx_read_valid", {31'b0, read_valid}, 32'h1);
    check("rx_ready_high", {31'b0, rx_ready}, 32'h1);
    step();
    io1_read = 1'b0;
    check("rx_underflow_data", read_data, 32'h0);
    read_status("unf_status", 32'h0000_0012);

    // Capture and read in one cycle with the register empty.
    rx_valid = 1'b1; rx_data = 32'hBEEF; io1_read = 1'b1;
    step();
    rx_valid = 1'b0;
    check("cap_read_zero", read_data, 32'h0);
    check("cap_read_full", {31'b0, rx_ready}, 32'h0);
    io2_read = 1'b1;
    step();
    io1_read = 1'b0; io2_read = 1'b0;
    check("io1_over_io2", read_data, 32'h0000_BEEF);

    // Three words queued with both sticky bits set, then clear all.
    for (int i = 0; i < 5; i++) push_word(32'h30 + 32'(i));
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    read_status("three_sticky", 32'h0000_0318);
    ctrl_write(32'h7);
    read_status("ctrl_clear", 32'h0000_0002);

    // Push in the same cycle as a flush is discarded.
    push_word(32'h55);
    check("pre_flush_valid", {31'b0, tx_valid}, 32'h1);
    io1_write = 1'b1; io2_write = 1'b1; write_data = 32'h4;
    step();
    io1_write = 1'b0; io2_write = 1'b0;
    check("flush_wins", {31'b0, tx_valid}, 32'h0);
    read_status("flush_status", 32'h0000_0002);

    // Reset mid-transfer.
    push_word(32'h77);
    rx_valid = 1'b1; rx_data = 32'h99;
    step();
    rx_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("midrst_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("midrst_read_data", read_data, 32'h0);

`ifdef IO_IRQ_EN
    check("irq_reset", {31'b0, irq}, 32'h0);
    ctrl_write(32'h8);
    rx_valid = 1'b1; rx_data = 32'h42;
    step();
    rx_valid = 1'b0;
    check("irq_lag", {31'b0, irq}, 32'h0);
    step();
    check("irq_set", {31'b0, irq}, 32'h1);
    io1_read = 1'b1;
    step();
    io1_read = 1'b0;
    check("irq_hold", {31'b0, irq}, 32'h1);
    step();
    check("irq_clear", {31'b0, irq}, 32'h0);
    read_status("ien_status", 32'h0000_0022);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Memory-mapped I/O peripheral that answers the CPU-side I/O strobes produced by the data-memory address decoder. Port 1 (word address 32768) is the data port and port 2 (word address 32772) is the status/control port. CPU stores to port 1 fill a transmit FIFO that drains to an external valid/ready sink. CPU loads from port 1 return the word held in a one-entry receive register, which an external valid/ready source fills.

## Interface
Parameters:
- DEPTH, 4: TX FIFO entries; power of two, 2..16.
- DATA_W, 32: data width of TX/RX words; 8..32, zero-extended onto the 32-bit bus.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- io1_write  in  1  store strobe, data port.
- io1_read  in  1  load strobe, data port.
- io2_write  in  1  store strobe, control port.
- io2_read  in  1  load strobe, status port.
- write_data  in  32  CPU store data.
- read_data  out  32  CPU load data; registered.
- read_valid  out  1  one-cycle pulse, read_data is updated.
- tx_data  out  DATA_W  FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts head.
- rx_data  in  DATA_W  source word.
- rx_valid  in  1  source word present.
- rx_ready  out  1  receive register empty.

## Operation
- Reset state: FIFO empty, rx_full=0, overflow=0, underflow=0, read_data=0, read_valid=0. As a result, tx_valid=0 and rx_ready=1.
- io1_write: push write_data[DATA_W-1:0].
  - If the FIFO is full and no pop occurs in the same cycle, the word is dropped and overflow is set (sticky).
  - A push and a pop in the same cycle on a full FIFO are both accepted, and the count is unchanged.
- TX drain: tx_valid = ~empty and tx_data = head. A pop happens when tx_valid & tx_ready.
- RX capture: rx_ready = ~rx_full. When rx_valid & rx_ready, rx_data is captured and rx_full is set.
- io1_read:
  - If rx_full: read_data = zero-extended RX word, and rx_full is cleared.
  - Otherwise: read_data = 0 and underflow is set (sticky).
  - If a capture and a read occur in the same cycle with the register empty, the read sees empty (returns 0, sets underflow) and the new word is captured.
- io2_read: read_data returns the status word.
  - Bit 0: full. Bit 1: empty. Bit 2: rx_full. Bit 3: overflow. Bit 4: underflow.
  - Bits [12:8]: FIFO count. All other bits are 0.
  - Status reflects pre-edge state.
- io2_write control bits:
  - Bit 0 = 1: clear overflow.
  - Bit 1 = 1: clear underflow.
  - Bit 2 = 1: flush the FIFO (count=0, pointers reset).
- Strobe priority:
  - Simultaneous io1_read and io2_read: io1_read is served and io2_read is ignored.
  - Flush in the same cycle as an io1_write: flush wins, the push is discarded, and overflow is not set.
  - Flush in the same cycle as a pop: flush wins.
  - Clear and set of the same sticky bit in one cycle: set wins.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.

## Timing
- Load latency is 1 cycle: strobe in cycle N gives read_data and read_valid in cycle N+1. read_data holds until the next load.
- Store effect is visible in status and tx_valid in cycle N+1.
- rx_ready falls the cycle after capture and rises the cycle after io1_read consumes the word.
- Back-to-back strobes are accepted every cycle.
- rst mid-transfer discards the FIFO contents and the RX word. All outputs return to their reset values on the edge where rst=1.

## Configuration
- IO_IRQ_EN defined:
  - Adds output irq (1 bit, registered, reset 0).
  - Adds interrupt-enable bits ien[1:0], set by io2_write bits [4:3] (written every io2_write) and readable at status bits [6:5].
  - irq = (rx_full & ien[0]) | (empty & ien[1]), registered one cycle.
- IO_IRQ_EN undefined: no irq port, no ien state, status bits [6:5] read 0.

## Test plan
- Reset: rst=1 for 2 cycles → read_data=0, tx_valid=0, rx_ready=1; io2_read → status 0x00000002.
- Fill to overflow: DEPTH=4, tx_ready=0, five io1_writes 0x11..0x15 → status count=4, full=1, overflow=1. Then tx_ready=1 → tx_data drains 0x11, 0x12, 0x13, 0x14, and 0x15 never appears.
- Full with concurrent pop: FIFO full, io1_write 0xAA while tx_ready=1 → count stays 4, overflow stays 0, and 0xAA is the last word drained.
- RX path: rx_valid with 0xCAFE → rx_ready=0 next cycle; io1_read → read_data=0x0000CAFE with read_valid pulse; a second io1_read → 0 and underflow=1.
- Control: io2_write 0x7 with FIFO holding 3 words and sticky bits set → status 0x00000002 next cycle. Same cycle io1_write + flush → FIFO empty.
- IO_IRQ_EN: io2_write 0x8, RX capture → irq=1 one cycle after rx_full; io1_read → irq=0 two cycles later.
